// File: rtl/i2c_switched_write_seq_pkg.sv
// Shared definitions for the switched I2C write sequencer.
//   seq_state_e     : sequencer FSM states
//   phase_e         : which bus byte is being written (switch select / payload / switch deselect)
//   ERR_*           : error codes reported on error_code
//   PCA9548_BASE    : fixed upper five bits of the PCA9548APW address
//   switch_addr()   : full 8-bit write address of the switch for a given FMC LOC
package i2c_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_NEXT,
      ST_ATTEMPT_FAIL,
      ST_GAP,
      ST_DONE,
      ST_FAIL
   } seq_state_e;

   typedef enum logic [1:0] {
      PH_SELECT,
      PH_PAYLOAD,
      PH_DESELECT
   } phase_e;

   localparam logic [2:0] ERR_NONE        = 3'd0;
   localparam logic [2:0] ERR_SELECT      = 3'd1;
   localparam logic [2:0] ERR_PAYLOAD     = 3'd2;
   localparam logic [2:0] ERR_DESELECT    = 3'd3;
   localparam logic [2:0] ERR_LENGTH      = 3'd4;
   localparam logic [2:0] ERR_PAY_TIMEOUT = 3'd5;

   localparam logic [4:0] PCA9548_BASE = 5'b11101;

   function automatic logic [7:0] switch_addr(input logic [1:0] loc);
      return {PCA9548_BASE, loc, 1'b0};
   endfunction

endpackage

// File: rtl/i2c_switched_write_seq_if.sv
// Byte-level handshake between the sequencer and the existing I2C byte master.
//   i2c_start_write   : sequencer -> master, held high while a byte is requested
//   i2c_dev_adr       : sequencer -> master, address byte ({addr7,1'b0})
//   i2c_reg_dat       : sequencer -> master, data byte
//   i2c_wr_byte_done  : master -> sequencer, byte finished
//   i2c_wr_byte_error : master -> sequencer, byte NAK/error
// modport master : the sequencer side; modport slave : the byte-master side.
interface i2c_switched_write_seq_if;

   logic       i2c_start_write;
   logic [7:0] i2c_dev_adr;
   logic [7:0] i2c_reg_dat;
   logic       i2c_wr_byte_done;
   logic       i2c_wr_byte_error;

   modport master (
      output i2c_start_write,
      output i2c_dev_adr,
      output i2c_reg_dat,
      input  i2c_wr_byte_done,
      input  i2c_wr_byte_error
   );

   modport slave (
      input  i2c_start_write,
      input  i2c_dev_adr,
      input  i2c_reg_dat,
      output i2c_wr_byte_done,
      output i2c_wr_byte_error
   );

endinterface

// File: rtl/i2c_switched_write_seq_watchdog.sv
// Saturating cycle counter used as the per-attempt byte watchdog and as the
// inter-attempt retry gap timer.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr_i        : synchronous clear to zero (wins over en_i)
//   en_i         : count one cycle
//   expired_o    : count has reached TIMEOUT_CYCLES-1, i.e. en_i has been
//                  high for TIMEOUT_CYCLES cycles since the last clear
module i2c_byte_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 250000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i && (cnt_q != LAST)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/i2c_switched_write_seq.sv
// Switched I2C write sequencer: opens a PCA9548APW channel, writes 0..MAX_BYTES
// payload bytes to a 7-bit target, then closes the switch, with per-byte retry,
// a byte watchdog and guaranteed switch deselect after a payload failure.
//   clk, reset_n      : 125 MHz clock, asynchronous active-low reset
//   sm_start          : one-cycle request, accepted only in IDLE
//   sm_running        : transaction in progress
//   fmc_loc           : FMC LOC bits of the switch address
//   channel_sel       : switch channel mask written during select
//   target_adr        : 7-bit target device address
//   num_bytes         : payload length
//   payload           : payload bytes, byte k at [8k+7:8k]
//   write_done        : one-cycle success pulse
//   write_error       : one-cycle failure pulse
//   error_code        : failure reason, valid from write_error to next start
//   i2c               : byte-master handshake (master modport)
module i2c_switched_write_seq
   import i2c_seq_pkg::*;
#(
   parameter int unsigned MAX_BYTES      = 4,
   parameter int unsigned MAX_RETRY      = 2,
   parameter int unsigned TIMEOUT_CYCLES = 250000,
   parameter int unsigned RETRY_GAP      = 1250
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   sm_start,
   output logic                   sm_running,
   input  logic [1:0]             fmc_loc,
   input  logic [7:0]             channel_sel,
   input  logic [6:0]             target_adr,
   input  logic [3:0]             num_bytes,
   input  logic [8*MAX_BYTES-1:0] payload,
   output logic                   write_done,
   output logic                   write_error,
   output logic [2:0]             error_code,
   i2c_switched_write_seq_if.master i2c
);

   localparam logic [3:0] MAX_N   = 4'(MAX_BYTES);
   localparam logic [2:0] MAX_RTY = 3'(MAX_RETRY);

   seq_state_e state_q;
   phase_e     phase_q;
   logic [3:0] idx_q;
   logic [2:0] retry_q;
   logic [3:0] nbytes_q;
   logic [1:0] loc_q;
   logic [7:0] ch_q;
   logic [6:0] tgt_q;
   logic [7:0] pay_q [16];
   logic [7:0] adr_q;
   logic [7:0] dat_q;
   logic       start_q;
   logic       running_q;
   logic       done_q;
   logic       error_q;
   logic [2:0] code_q;
   logic [2:0] pend_q;
   logic       last_to_q;
   logic       wd_expired;
   logic       gap_expired;

   i2c_byte_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_byte_wd (
      .clk       (clk),
      .reset_n   (reset_n),
      .clr_i     (state_q == ST_REQ),
      .en_i      (state_q == ST_WAIT),
      .expired_o (wd_expired)
   );

   i2c_byte_watchdog #(.TIMEOUT_CYCLES(RETRY_GAP)) u_gap_wd (
      .clk       (clk),
      .reset_n   (reset_n),
      .clr_i     (state_q == ST_ATTEMPT_FAIL),
      .en_i      (state_q == ST_GAP),
      .expired_o (gap_expired)
   );

   // Address/data pair for a phase, built from the latched request.
   function automatic logic [15:0] bus_word(input phase_e ph, input logic [3:0] idx);
      case (ph)
         PH_SELECT:  return {switch_addr(loc_q), ch_q};
         PH_PAYLOAD: return {tgt_q, 1'b0, pay_q[idx]};
         default:    return {switch_addr(loc_q), 8'h00};
      endcase
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         phase_q   <= PH_SELECT;
         idx_q     <= '0;
         retry_q   <= '0;
         nbytes_q  <= '0;
         loc_q     <= '0;
         ch_q      <= '0;
         tgt_q     <= '0;
         for (int unsigned k = 0; k < 16; k++) pay_q[k] <= '0;
         adr_q     <= '0;
         dat_q     <= '0;
         start_q   <= 1'b0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         code_q    <= ERR_NONE;
         pend_q    <= ERR_NONE;
         last_to_q <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (sm_start) begin
                  code_q  <= ERR_NONE;
                  pend_q  <= ERR_NONE;
                  retry_q <= '0;
                  if (num_bytes > MAX_N) begin
                     code_q  <= ERR_LENGTH;
                     error_q <= 1'b1;
                     state_q <= ST_FAIL;
                  end else begin
                     loc_q    <= fmc_loc;
                     ch_q     <= channel_sel;
                     tgt_q    <= target_adr;
                     nbytes_q <= num_bytes;
                     for (int unsigned k = 0; k < MAX_BYTES; k++) pay_q[k] <= payload[8*k +: 8];
                     phase_q   <= PH_SELECT;
                     idx_q     <= '0;
                     adr_q     <= switch_addr(fmc_loc);
                     dat_q     <= channel_sel;
                     running_q <= 1'b1;
                     state_q   <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               start_q <= 1'b1;
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               // A NAK takes priority over a simultaneous done or watchdog expiry.
               if (i2c.i2c_wr_byte_error || wd_expired) begin
                  start_q   <= 1'b0;
                  last_to_q <= !i2c.i2c_wr_byte_error;
                  state_q   <= ST_ATTEMPT_FAIL;
               end else if (i2c.i2c_wr_byte_done) begin
                  start_q <= 1'b0;
                  state_q <= ST_NEXT;
               end
            end
            ST_NEXT: begin
               retry_q <= '0;
               state_q <= ST_REQ;
               if (phase_q == PH_DESELECT) begin
                  running_q <= 1'b0;
                  if (pend_q != ERR_NONE) begin
                     code_q  <= pend_q;
                     error_q <= 1'b1;
                     state_q <= ST_FAIL;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end
               end else if ((phase_q == PH_SELECT && nbytes_q == 4'd0) ||
                            (phase_q == PH_PAYLOAD && idx_q + 4'd1 == nbytes_q)) begin
                  phase_q          <= PH_DESELECT;
                  {adr_q, dat_q}   <= bus_word(PH_DESELECT, idx_q);
               end else if (phase_q == PH_SELECT) begin
                  phase_q          <= PH_PAYLOAD;
                  idx_q            <= '0;
                  {adr_q, dat_q}   <= bus_word(PH_PAYLOAD, 4'd0);
               end else begin
                  idx_q            <= idx_q + 4'd1;
                  {adr_q, dat_q}   <= bus_word(PH_PAYLOAD, idx_q + 4'd1);
               end
            end
            ST_ATTEMPT_FAIL: begin
               if (retry_q < MAX_RTY) begin
                  retry_q <= retry_q + 3'd1;
                  state_q <= ST_GAP;
               end else begin
                  case (phase_q)
                     PH_SELECT: begin
                        code_q    <= ERR_SELECT;
                        error_q   <= 1'b1;
                        running_q <= 1'b0;
                        state_q   <= ST_FAIL;
                     end
                     PH_PAYLOAD: begin
                        // Payload failure still closes the switch; the code is
                        // reported once deselect completes (or is replaced by 3).
                        pend_q         <= last_to_q ? ERR_PAY_TIMEOUT : ERR_PAYLOAD;
                        phase_q        <= PH_DESELECT;
                        retry_q        <= '0;
                        {adr_q, dat_q} <= bus_word(PH_DESELECT, idx_q);
                        state_q        <= ST_REQ;
                     end
                     default: begin
                        code_q    <= ERR_DESELECT;
                        error_q   <= 1'b1;
                        running_q <= 1'b0;
                        state_q   <= ST_FAIL;
                     end
                  endcase
               end
            end
            ST_GAP: begin
               if (gap_expired) state_q <= ST_REQ;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign sm_running          = running_q;
   assign write_done          = done_q;
   assign write_error         = error_q;
   assign error_code          = code_q;
   assign i2c.i2c_start_write = start_q;
   assign i2c.i2c_dev_adr     = adr_q;
   assign i2c.i2c_reg_dat     = dat_q;

endmodule

// File: tb/tb_i2c_switched_write_seq.sv
module tb_i2c_switched_write_seq;

   localparam int unsigned MAX_BYTES = 4;
   localparam int unsigned MAX_RETRY = 2;
   localparam int unsigned TIMEOUT   = 40;
   localparam int unsigned GAP       = 12;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        sm_start = 1'b0;
   logic        sm_running;
   logic [1:0]  fmc_loc = '0;
   logic [7:0]  channel_sel = '0;
   logic [6:0]  target_adr = '0;
   logic [3:0]  num_bytes = '0;
   logic [31:0] payload = '0;
   logic        write_done;
   logic        write_error;
   logic [2:0]  error_code;

   i2c_switched_write_seq_if i2c();

   i2c_switched_write_seq #(
      .MAX_BYTES      (MAX_BYTES),
      .MAX_RETRY      (MAX_RETRY),
      .TIMEOUT_CYCLES (TIMEOUT),
      .RETRY_GAP      (GAP)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .sm_start    (sm_start),
      .sm_running  (sm_running),
      .fmc_loc     (fmc_loc),
      .channel_sel (channel_sel),
      .target_adr  (target_adr),
      .num_bytes   (num_bytes),
      .payload     (payload),
      .write_done  (write_done),
      .write_error (write_error),
      .error_code  (error_code),
      .i2c         (i2c.master)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endfunction

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [7:0] adr;
      logic [7:0] dat;
      logic       retry;
   } xfer_t;

   xfer_t      exp_q[$];
   logic       exp_done;
   logic [2:0] exp_code;
   int         resp[$];   // per-attempt response: 0 ack, 1 NAK, 2 silent

   // Bus bytes form the list: select, payload 0..nb-1, deselect. Each is tried
   // up to MAX_RETRY+1 times; the response script decides each attempt.
   task automatic build_model(input int nb, input logic [1:0] loc, input logic [7:0] ch,
                              input logic [6:0] tgt, input logic [31:0] pay, input int script[$]);
      int s;
      int pend;
      int last;
      int r;
      bit ok;
      logic [7:0] sw;
      logic [7:0] a;
      logic [7:0] d;
      s = 0; pend = 0; last = 0;
      sw = 8'hE8 | {5'd0, loc, 1'b0};
      exp_q.delete();
      exp_done = 1'b0;
      exp_code = 3'd0;
      if (nb > int'(MAX_BYTES)) begin
         exp_code = 3'd4;
         return;
      end
      for (int ph = 0; ph < nb + 2; ph++) begin
         if (ph == 0)           begin a = sw;           d = ch; end
         else if (ph == nb + 1) begin a = sw;           d = 8'h00; end
         else                   begin a = {tgt, 1'b0};  d = pay[8*(ph-1) +: 8]; end
         ok = 1'b0;
         for (int at = 0; at <= int'(MAX_RETRY) && !ok; at++) begin
            exp_q.push_back({a, d, (at > 0)});
            r = (s < script.size()) ? script[s] : 0;
            s++;
            if (r == 0) ok = 1'b1;
            else last = r;
         end
         if (!ok) begin
            if (ph == 0) begin exp_code = 3'd1; return; end
            if (ph == nb + 1) begin exp_code = 3'd3; return; end
            pend = (last == 2) ? 5 : 2;
            ph = nb;
         end
      end
      if (pend != 0) exp_code = 3'(pend);
      else exp_done = 1'b1;
   endtask

   // ---------------- byte-master responder ----------------
   initial begin
      int r;
      int n;
      i2c.i2c_wr_byte_done  = 1'b0;
      i2c.i2c_wr_byte_error = 1'b0;
      forever begin
         @(negedge clk);
         if (reset_n && i2c.i2c_start_write) begin
            r = (resp.size() > 0) ? resp.pop_front() : 0;
            if (r != 2) begin
               repeat (2) @(negedge clk);
               if (r == 0) i2c.i2c_wr_byte_done = 1'b1;
               else        i2c.i2c_wr_byte_error = 1'b1;
               @(negedge clk);
               i2c.i2c_wr_byte_done  = 1'b0;
               i2c.i2c_wr_byte_error = 1'b0;
            end
            n = 0;
            while (i2c.i2c_start_write && n < 10000) begin
               @(negedge clk);
               n++;
            end
         end
      end
   end

   // ---------------- compare process ----------------
   int    rise_cnt = 0;
   int    pulse_cnt = 0;
   int    low_cnt = 0;
   logic  prev_start = 1'b0;
   logic [7:0] prev_adr = '0;
   logic [7:0] prev_dat = '0;
   xfer_t cur;

   always @(negedge clk) begin
      if (!reset_n) begin
         prev_start = 1'b0;
         low_cnt    = 0;
      end else begin
         if (i2c.i2c_start_write && !prev_start) begin
            rise_cnt++;
            if (exp_q.size() == 0) begin
               chk("unexpected_byte", {i2c.i2c_dev_adr, i2c.i2c_reg_dat}, 16'h0);
               cur = '0;
            end else begin
               cur = exp_q.pop_front();
               chk("byte", {i2c.i2c_dev_adr, i2c.i2c_reg_dat}, {cur.adr, cur.dat});
               chk("byte_setup", {prev_adr, prev_dat}, {cur.adr, cur.dat});
               if (cur.retry) chk("retry_gap_ok", (low_cnt >= int'(GAP)), 1);
            end
         end else if (i2c.i2c_start_write) begin
            chk("byte_hold", {i2c.i2c_dev_adr, i2c.i2c_reg_dat}, {cur.adr, cur.dat});
         end
         if (write_done || write_error) begin
            pulse_cnt++;
            chk("result_kind", {write_done, write_error}, {exp_done, !exp_done});
            if (write_error) chk("error_code", error_code, exp_code);
         end
         low_cnt = i2c.i2c_start_write ? 0 : low_cnt + 1;
      end
      prev_start = i2c.i2c_start_write;
      prev_adr   = i2c.i2c_dev_adr;
      prev_dat   = i2c.i2c_reg_dat;
   end

   // ---------------- stimulus ----------------
   task automatic exec(input logic [3:0] nb, input logic [1:0] loc, input logic [7:0] ch,
                       input logic [6:0] tgt, input logic [31:0] pay, input bit poke);
      int base;
      int n;
      base = pulse_cnt;
      @(negedge clk);
      num_bytes = nb; fmc_loc = loc; channel_sel = ch; target_adr = tgt; payload = pay;
      sm_start = 1'b1;
      @(negedge clk);
      sm_start = 1'b0;
      chk("running_after_start", sm_running, (nb <= 4'(MAX_BYTES)) ? 1 : 0);
      // changes after acceptance must not leak into the transaction
      num_bytes = 4'd1; fmc_loc = ~loc; channel_sel = ~ch; target_adr = ~tgt; payload = ~pay;
      if (poke) begin
         repeat (6) @(negedge clk);
         sm_start = 1'b1;
         @(negedge clk);
         sm_start = 1'b0;
      end
      n = 0;
      while (pulse_cnt == base && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("pulse_seen", (pulse_cnt != base), 1);
      chk("all_bytes_sent", exp_q.size(), 0);
      repeat (3) @(negedge clk);
      chk("code_hold", error_code, exp_code);
      chk("one_pulse", pulse_cnt - base, 1);
      chk("idle_running", sm_running, 0);
   endtask

   task automatic prep(input int nb, input logic [1:0] loc, input logic [7:0] ch,
                       input logic [6:0] tgt, input logic [31:0] pay, input int script[$]);
      build_model(nb, loc, ch, tgt, pay, script);
      resp = script;
   endtask

   initial begin
      int s[$];
      int base;
      int n;
      repeat (3) @(negedge clk);
      chk("rst_running", sm_running, 0);
      chk("rst_start", i2c.i2c_start_write, 0);
      chk("rst_done_err", {write_done, write_error}, 0);
      chk("rst_code", error_code, 0);
      chk("rst_bus", {i2c.i2c_dev_adr, i2c.i2c_reg_dat}, 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_start", i2c.i2c_start_write, 0);

      // three-byte write, with a start pulse during the run
      s = {};
      prep(3, 2'd2, 8'h04, 7'h38, 32'h00332211, s);
      chk("model_len3", exp_q.size(), 5);
      chk("model_sel", {exp_q[0].adr, exp_q[0].dat}, 16'hEC04);
      chk("model_p0", {exp_q[1].adr, exp_q[1].dat}, 16'h7011);
      chk("model_p2", {exp_q[3].adr, exp_q[3].dat}, 16'h7033);
      chk("model_desel", {exp_q[4].adr, exp_q[4].dat}, 16'hEC00);
      exec(4'd3, 2'd2, 8'h04, 7'h38, 32'h00332211, 1'b1);
      chk("t1_code", error_code, 3'd0);

      // zero-length write
      prep(0, 2'd1, 8'h81, 7'h50, 32'hDEADBEEF, s);
      chk("model_len0", exp_q.size(), 2);
      exec(4'd0, 2'd1, 8'h81, 7'h50, 32'hDEADBEEF, 1'b0);

      // full-length write
      prep(4, 2'd3, 8'h10, 7'h7F, 32'hA1B2C3D4, s);
      exec(4'd4, 2'd3, 8'h10, 7'h7F, 32'hA1B2C3D4, 1'b0);

      // bad length
      prep(5, 2'd0, 8'h01, 7'h22, 32'h0, s);
      chk("model_badlen", {exp_q.size() == 0, exp_code}, {1'b1, 3'd4});
      exec(4'd5, 2'd0, 8'h01, 7'h22, 32'h0, 1'b0);
      chk("badlen_code", error_code, 3'd4);

      // payload byte 1 NAKed twice then acked
      s = {0, 0, 1, 1, 0};
      prep(3, 2'd0, 8'h02, 7'h11, 32'h00CCBBAA, s);
      chk("model_retry_len", exp_q.size(), 7);
      exec(4'd3, 2'd0, 8'h02, 7'h11, 32'h00CCBBAA, 1'b0);

      // payload byte 0 NAK exhausted -> deselect, code 2
      s = {0, 1, 1, 1};
      prep(2, 2'd1, 8'h08, 7'h33, 32'h00005566, s);
      exec(4'd2, 2'd1, 8'h08, 7'h33, 32'h00005566, 1'b0);
      chk("pay_nak_code", error_code, 3'd2);

      // payload byte 0 silent -> timeouts, code 5
      s = {0, 2, 2, 2};
      prep(2, 2'd1, 8'h08, 7'h33, 32'h00005566, s);
      exec(4'd2, 2'd1, 8'h08, 7'h33, 32'h00005566, 1'b0);
      chk("pay_to_code", error_code, 3'd5);

      // select NAK exhausted, code 1, no further bytes
      s = {1, 1, 1};
      prep(2, 2'd2, 8'h40, 7'h44, 32'h00001234, s);
      chk("model_selfail_len", exp_q.size(), 3);
      exec(4'd2, 2'd2, 8'h40, 7'h44, 32'h00001234, 1'b0);
      chk("sel_code", error_code, 3'd1);

      // deselect NAK exhausted, code 3
      s = {0, 0, 1, 1, 1};
      prep(1, 2'd3, 8'h20, 7'h55, 32'h00000099, s);
      exec(4'd1, 2'd3, 8'h20, 7'h55, 32'h00000099, 1'b0);
      chk("desel_code", error_code, 3'd3);

      // payload failure followed by deselect failure: code 3 replaces 2
      s = {0, 1, 1, 1, 1, 1, 1};
      prep(1, 2'd3, 8'h20, 7'h55, 32'h00000099, s);
      exec(4'd1, 2'd3, 8'h20, 7'h55, 32'h00000099, 1'b0);
      chk("override_code", error_code, 3'd3);

      // reset during WAIT of payload byte 2
      s = {};
      prep(3, 2'd1, 8'h80, 7'h20, 32'h00AA5544, s);
      base = rise_cnt;
      @(negedge clk);
      num_bytes = 4'd3; fmc_loc = 2'd1; channel_sel = 8'h80; target_adr = 7'h20; payload = 32'h00AA5544;
      sm_start = 1'b1;
      @(negedge clk);
      sm_start = 1'b0;
      n = 0;
      while (rise_cnt < base + 4 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("reset_point_reached", (rise_cnt >= base + 4), 1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_start", i2c.i2c_start_write, 0);
      chk("async_rst_running", sm_running, 0);
      exp_q.delete();
      resp.delete();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_code", error_code, 0);

      // fresh transaction after reset starts at select
      prep(2, 2'd0, 8'h01, 7'h60, 32'h0000BEEF, s);
      exec(4'd2, 2'd0, 8'h01, 7'h60, 32'h0000BEEF, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: got no completion expected $finish");
      $fatal(1, "timeout");
   end

endmodule
